// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER point-stream driver and coverage checker.
package laser_pkg;

  localparam int unsigned COORD_W   = 4;
  localparam int unsigned NUM_PTS   = 40;
  localparam int unsigned RADIUS_SQ = 16;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned SCORE_W   = 6;
  localparam int unsigned SQ_W      = 2 * COORD_W;
  localparam int unsigned DIST_W    = 2 * COORD_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StPrst,
    StGap,
    StSend,
    StWait,
    StScore,
    StReport
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Squared Euclidean distance; the sum of two squares needs one extra bit (max 450).
  function automatic logic [DIST_W-1:0] dist_sq(input point_t p, input point_t c);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [SQ_W-1:0]    sx;
    logic [SQ_W-1:0]    sy;
    dx = abs_diff(p.x, c.x);
    dy = abs_diff(p.y, c.y);
    sx = SQ_W'(dx) * SQ_W'(dx);
    sy = SQ_W'(dy) * SQ_W'(dy);
    return {1'b0, sx} + {1'b0, sy};
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational check: is a point within the squared radius of either of two centres.
module laser_cover_chk
  import laser_pkg::*;
(
  input  point_t pt,
  input  point_t c1,
  input  point_t c2,
  output logic   covered
);

  logic [DIST_W-1:0] d1;
  logic [DIST_W-1:0] d2;

  always_comb begin
    d1      = dist_sq(pt, c1);
    d2      = dist_sq(pt, c2);
    covered = (d1 <= DIST_W'(RADIUS_SQ)) || (d2 <= DIST_W'(RADIUS_SQ));
  end

endmodule

// File: rtl/laser_pattern_driver.sv
// Streams a host-loaded point bank into the LASER core and scores its answer.
// Define LASER_DRV_TIMEOUT_EN to bound the wait for DONE by TIMEOUT_CYC cycles.
module laser_pattern_driver
  import laser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
)
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               start,
  output logic               busy,
  output logic               dut_rst,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic               DONE,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  output logic [COORD_W-1:0] res_c1x,
  output logic [COORD_W-1:0] res_c1y,
  output logic [COORD_W-1:0] res_c2x,
  output logic [COORD_W-1:0] res_c2y,
  output logic [SCORE_W-1:0] score,
  output logic               result_valid,
  output logic               timeout
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PTS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  point_t           bank [NUM_PTS];
  point_t           send_pt;
  point_t           score_pt;
  logic             covered;

  // Bank is deliberately not reset so a pattern survives an aborted run.
  always_ff @(posedge CLK) begin
    if (wr_en && (state_q == StIdle) && (wr_addr < IDX_W'(NUM_PTS))) begin
      bank[wr_addr] <= '{x: wr_x, y: wr_y};
    end
  end

  always_comb begin
    idx_nxt  = idx_q + 1'b1;
    send_pt  = (state_q == StGap) ? bank[0] : bank[idx_nxt];
    score_pt = bank[idx_q];
  end

  laser_cover_chk u_cover_chk (
    .pt      (score_pt),
    .c1      ('{x: res_c1x, y: res_c1y}),
    .c2      ('{x: res_c2x, y: res_c2y}),
    .covered (covered)
  );

  assign busy = (state_q != StIdle);

`ifdef LASER_DRV_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      dut_rst      <= 1'b0;
      X            <= '0;
      Y            <= '0;
      res_c1x      <= '0;
      res_c1y      <= '0;
      res_c2x      <= '0;
      res_c2y      <= '0;
      score        <= '0;
      result_valid <= 1'b0;
`ifdef LASER_DRV_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      dut_rst      <= 1'b0;
      result_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StPrst;
            dut_rst <= 1'b1;
`ifdef LASER_DRV_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        StPrst: state_q <= StGap;
        StGap: begin
          state_q <= StSend;
          idx_q   <= '0;
          {X, Y}  <= send_pt;
        end
        StSend: begin
          if (idx_q == LastIdx) begin
            state_q <= StWait;
            X       <= '0;
            Y       <= '0;
`ifdef LASER_DRV_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end else begin
            idx_q  <= idx_nxt;
            {X, Y} <= send_pt;
          end
        end
        StWait: begin
          // DONE is checked first so it wins over a same-edge expiry.
          if (DONE) begin
            state_q <= StScore;
            idx_q   <= '0;
            score   <= '0;
            res_c1x <= C1X;
            res_c1y <= C1Y;
            res_c2x <= C2X;
            res_c2y <= C2Y;
          end
`ifdef LASER_DRV_TIMEOUT_EN
          else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_q      <= StReport;
            result_valid <= 1'b1;
            timeout_q    <= 1'b1;
            score        <= '0;
            res_c1x      <= '0;
            res_c1y      <= '0;
            res_c2x      <= '0;
            res_c2y      <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        StScore: begin
          score <= score + SCORE_W'(covered);
          if (idx_q == LastIdx) begin
            state_q      <= StReport;
            result_valid <= 1'b1;
          end else begin
            idx_q <= idx_nxt;
          end
        end
        StReport: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_pattern_driver.sv
// Scoreboard bench for laser_pattern_driver with a small behavioural LASER core model.
module tb_laser_pattern_driver;
  import laser_pkg::*;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         wr_en = 1'b0;
  logic [5:0]   wr_addr = '0;
  logic [3:0]   wr_x = '0;
  logic [3:0]   wr_y = '0;
  logic         start = 1'b0;
  logic         busy;
  logic         dut_rst;
  logic [3:0]   X;
  logic [3:0]   Y;
  logic         DONE = 1'b0;
  logic [3:0]   C1X = '0;
  logic [3:0]   C1Y = '0;
  logic [3:0]   C2X = '0;
  logic [3:0]   C2Y = '0;
  logic [3:0]   res_c1x;
  logic [3:0]   res_c1y;
  logic [3:0]   res_c2x;
  logic [3:0]   res_c2y;
  logic [5:0]   score;
  logic         result_valid;
  logic         timeout;

  always #5 CLK = ~CLK;

  laser_pattern_driver #(
    .TIMEOUT_CYC (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .start        (start),
    .busy         (busy),
    .dut_rst      (dut_rst),
    .X            (X),
    .Y            (Y),
    .DONE         (DONE),
    .C1X          (C1X),
    .C1Y          (C1Y),
    .C2X          (C2X),
    .C2Y          (C2Y),
    .res_c1x      (res_c1x),
    .res_c1y      (res_c1y),
    .res_c2x      (res_c2x),
    .res_c2y      (res_c2y),
    .score        (score),
    .result_valid (result_valid),
    .timeout      (timeout)
  );

  typedef struct {
    int          sc;
    logic [15:0] res;
    logic        to;
  } res_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] stream_q[$];
  res_t        res_q[$];
  logic [7:0]  mbank [40];

  // Core model controls
  logic [15:0] model_c = '0;
  int          done_delay = 0;
  bit          glitch = 0;
  bit          never_done = 0;
  bit          armed = 0;
  int          mcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Core model: counts negedges from its reset pulse; DONE lands in the first WAIT cycle
  // plus done_delay. A glitch DONE during SEND must be ignored by the driver.
  always @(negedge CLK) begin
    if (RST) armed = 0;
    else if (dut_rst) begin
      armed = 1;
      mcnt  = 0;
    end else if (armed) mcnt++;
    DONE = 1'b0;
    if (armed && glitch && mcnt == 10) DONE = 1'b1;
    if (armed && !never_done && mcnt == 42 + done_delay) begin
      DONE  = 1'b1;
      armed = 0;
    end
    {C1X, C1Y, C2X, C2Y} = model_c;
  end

  logic [31:0] exp_s;
  always @(negedge CLK) begin
    if (stream_q.size() > 0) begin
      exp_s = stream_q.pop_front();
      check("stream", {23'b0, dut_rst, X, Y}, exp_s);
    end
  end

  res_t r;
  always @(negedge CLK) begin
    if (result_valid) begin
      if (res_q.size() == 0) check("unexpected_result_valid", {31'b0, result_valid}, 32'd0);
      else begin
        r = res_q.pop_front();
        check("score", {26'b0, score}, r.sc);
        check("res", {16'b0, res_c1x, res_c1y, res_c2x, res_c2y}, {16'b0, r.res});
        check("timeout", {31'b0, timeout}, {31'b0, r.to});
      end
    end
  end

  task automatic write_pt(input int addr, input int x, input int y);
    @(posedge CLK); #1;
    wr_en = 1'b1; wr_addr = 6'(addr); wr_x = 4'(x); wr_y = 4'(y);
    @(posedge CLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic model_wr(input int addr, input int x, input int y);
    if (addr < 40) mbank[addr] = {4'(x), 4'(y)};
  endtask

  // Issues start (optionally with a same-cycle write) and queues the expected stream
  // for n streamed points followed by one quiet cycle.
  task automatic run_start(input int n, input bit wr_with, input int addr, input int x,
                           input int y);
    @(posedge CLK); #1;
    start = 1'b1;
    if (wr_with) begin
      wr_en = 1'b1; wr_addr = 6'(addr); wr_x = 4'(x); wr_y = 4'(y);
      model_wr(addr, x, y);
    end
    @(posedge CLK); #1;
    start = 1'b0;
    wr_en = 1'b0;
    stream_q.push_back(32'h100);
    stream_q.push_back(32'h000);
    for (int i = 0; i < n; i++) stream_q.push_back({24'b0, mbank[i]});
    stream_q.push_back(32'h000);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((res_q.size() != 0 || busy) && n < 300) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 300) begin
      check("result_wait", res_q.size(), 32'd0);
      res_q.delete();
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic expect_res(input int sc, input logic [15:0] res, input logic to);
    res_t e;
    e.sc = sc; e.res = res; e.to = to;
    res_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_dut_rst", {31'b0, dut_rst}, 0);
    check("rst_xy", {24'b0, X, Y}, 0);
    check("rst_res", {16'b0, res_c1x, res_c1y, res_c2x, res_c2y}, 0);
    check("rst_score", {26'b0, score}, 0);
    check("rst_result_valid", {31'b0, result_valid}, 0);
    check("rst_timeout", {31'b0, timeout}, 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // All points at (2,2), one centre on them
    for (int i = 0; i < 40; i++) begin write_pt(i, 2, 2); model_wr(i, 2, 2); end
    model_c = 16'h22CC;
    expect_res(40, 16'h22CC, 1'b0);
    run_start(40, 0, 0, 0, 0);
    wait_done();

    // Two clusters exactly on the radius boundary; late DONE and a spurious DONE in SEND
    for (int i = 0; i < 40; i++) begin
      write_pt(i, (i < 20) ? 0 : 15, (i < 20) ? 0 : 15);
      model_wr(i, (i < 20) ? 0 : 15, (i < 20) ? 0 : 15);
    end
    model_c = 16'h40FB; done_delay = 3; glitch = 1;
    expect_res(40, 16'h40FB, 1'b0);
    run_start(40, 0, 0, 0, 0);
    wait_done();

    // C1 moved to (4,1): origin cluster just outside
    model_c = 16'h41FB; done_delay = 0; glitch = 0;
    expect_res(20, 16'h41FB, 1'b0);
    run_start(40, 0, 0, 0, 0);
    wait_done();
    repeat (4) @(negedge CLK);
    check("score_hold", {26'b0, score}, 20);
    check("res_hold", {16'b0, res_c1x, res_c1y, res_c2x, res_c2y}, 32'h41FB);

    // Abort with RST while point 17 is on the bus
    model_c = 16'h40FB;
    run_start(18, 0, 0, 0, 0);
    repeat (19) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("abort_busy", {31'b0, busy}, 0);
    wait_done();

    // Rerun; a write attempted during SEND must be dropped
    expect_res(40, 16'h40FB, 1'b0);
    run_start(40, 0, 0, 0, 0);
    repeat (4) @(posedge CLK);
    #1 wr_en = 1'b1; wr_addr = 6'd5; wr_x = 4'd9; wr_y = 4'd9;
    @(posedge CLK); #1;
    wr_en = 1'b0;
    wait_done();

    // Out-of-range address in IDLE leaves the bank alone
    write_pt(45, 9, 9);
    expect_res(40, 16'h40FB, 1'b0);
    run_start(40, 0, 0, 0, 0);
    wait_done();

    // Point covered by both circles counts once; point 39 written with start
    for (int i = 0; i < 39; i++) begin write_pt(i, 7, 7); model_wr(i, 7, 7); end
    model_c = 16'h7777;
    expect_res(40, 16'h7777, 1'b0);
    run_start(40, 1, 39, 7, 7);
    wait_done();

`ifdef LASER_DRV_TIMEOUT_EN
    never_done = 1;
    expect_res(0, 16'h0000, 1'b1);
    run_start(40, 0, 0, 0, 0);
    wait_done();
    check("timeout_sticky", {31'b0, timeout}, 1);
    never_done = 0;
    expect_res(40, 16'h7777, 1'b0);
    run_start(40, 0, 0, 0, 0);
    @(negedge CLK);
    check("timeout_cleared", {31'b0, timeout}, 0);
    wait_done();
`endif

    check("stream_drained", stream_q.size(), 0);
    check("results_drained", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/laser_pattern_driver.md
Name: laser_pattern_driver

Overview:
- Stimulus/checker end of the LASER point-stream interface.
- Holds a host-loaded bank of NUM_PTS points and resets the LASER core.
- Streams the points one per cycle on X/Y, waits for DONE and captures C1X/C1Y/C2X/C2Y.
- Scores the answer: number of points inside either radius-4 circle. Used by the system test harness and the on-chip self-test.

Parameters:
- NUM_PTS, 40, points per pattern; also sets the bank depth.
- COORD_W, 4, coordinate width.
- RADIUS_SQ, 16, inclusive squared coverage radius.
- TIMEOUT_CYC, 1023, max cycles waiting for DONE (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- wr_en  in  1  bank write strobe; accepted only in IDLE.
- wr_addr  in  6  bank index 0..NUM_PTS-1; writes to higher addresses are ignored.
- wr_x, wr_y  in  COORD_W each  point to store.
- start  in  1  begin one run; accepted only in IDLE.
- busy  out  1  high in every state except IDLE.
- dut_rst  out  1  reset to the LASER core.
- X, Y  out  COORD_W each  point stream to the core.
- DONE  in  1  core result strobe.
- C1X, C1Y, C2X, C2Y  in  COORD_W each  core result.
- res_c1x, res_c1y, res_c2x, res_c2y  out  COORD_W each  captured centres.
- score  out  6  covered-point count, 0..NUM_PTS.
- result_valid  out  1  one-cycle pulse when score and res_* are final.
- timeout  out  1  sticky error flag; stays 0 without the optional feature.

Behaviour:
- Reset (RST=1 at a CLK edge): state IDLE, cycle counter 0, all outputs 0, including X, Y, dut_rst, res_*, score, result_valid, timeout.
  - The bank contents are not reset.
  - RST asserted in any state aborts the run. It does not pulse dut_rst.
- States: IDLE -> PRST -> GAP -> SEND -> WAIT -> SCORE -> REPORT -> IDLE.
- IDLE:
  - wr_en writes bank[wr_addr] = {wr_x, wr_y}.
  - start=1 -> PRST. If wr_en and start are high in the same cycle, the write lands and the run uses the new value.
  - start clears timeout.
- PRST: dut_rst=1 for exactly one cycle -> GAP.
- GAP: one idle cycle, matching the core's one-cycle IDLE; X=Y=0 -> SEND.
- SEND:
  - Index i runs 0..NUM_PTS-1; X/Y = bank[i] registered, one point per cycle, no gaps.
  - After i=NUM_PTS-1 -> WAIT; X/Y return to 0.
- WAIT:
  - DONE=1 -> capture C1X..C2Y into res_* on that edge -> SCORE.
  - DONE=1 seen during SEND is ignored.
- SCORE:
  - One point per cycle, j = 0..NUM_PTS-1.
  - Per-axis diff = |p - c| (COORD_W bits); square is 2*COORD_W bits; distance sum is 2*COORD_W+1 bits (max 450).
  - The point is covered if d1 <= RADIUS_SQ or d2 <= RADIUS_SQ; each point counts at most once.
  - score accumulates; it is cleared on entry to SCORE.
  - After j=NUM_PTS-1 -> REPORT.
- REPORT: result_valid=1 for one cycle -> IDLE.
  - score and res_* hold until the next start's SCORE entry or a reset.
- Latency from start to result_valid: 1+1+NUM_PTS + (WAIT cycles) + NUM_PTS + 1.

Optional Feature:
- LASER_DRV_TIMEOUT_EN defined:
  - WAIT counts cycles. If TIMEOUT_CYC elapse without DONE: timeout=1, score=0, res_*=0, then go to REPORT and pulse result_valid.
  - DONE arriving on the same edge as expiry wins.
- Not defined: WAIT has no limit, no counter logic is built, and timeout is tied to 0.

Decomposition:
- Package laser_pkg holds:
  - COORD_W, NUM_PTS, RADIUS_SQ;
  - the state enum (IDLE, PRST, GAP, SEND, WAIT, SCORE, REPORT);
  - a point struct {x, y}.
- One sub-module, laser_cover_chk: combinational; inputs are a point and two centres; output is a covered bit (two squared-distance compares). It is reused later by the core's own search.

Test Plan:
- Load 40 points all at (2,2), start, model core returns DONE with C1=(2,2), C2=(12,12) -> X/Y stream exactly 40 cycles starting 2 cycles after start; score=40; result_valid pulses once.
- Points 0..19 at (0,0), points 20..39 at (15,15), result C1=(4,0), C2=(15,11) -> (0,0) gives d1=16 (covered), (15,15) gives d2=16 (covered); score=40. Move C1 to (4,1): d1=17, so score=20.
- A point covered by both circles, e.g. C1=C2=(7,7) with all points at (7,7) -> score=40, not 80.
- RST asserted mid-SEND at i=17 -> next cycle IDLE, X=Y=0, busy=0, no result_valid; bank retained, and a rerun streams the same values.
- wr_en during SEND at addr 5 -> ignored, stream unchanged; wr_addr=45 in IDLE -> no bank change.
- With LASER_DRV_TIMEOUT_EN and TIMEOUT_CYC=8, model never raises DONE -> timeout=1, score=0, result_valid after 8 WAIT cycles; next start clears timeout.
